// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths and the write-back entry layout {rd, data}
package wb_arbiter_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: issue, result, hazard-query and register-file write signals of the write-back stage
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;
  logic                  iss_valid;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic                  iss_ready;
  logic                  ex_valid;
  logic [ADDR_WIDTH-1:0] ex_rd;
  logic [DATA_WIDTH-1:0] ex_data;
  logic                  ex_ready;
  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_rd;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_ready;
  logic [ADDR_WIDTH-1:0] q_raddr1;
  logic [ADDR_WIDTH-1:0] q_raddr2;
  logic                  q_busy1;
  logic                  q_busy2;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  modport slave (
    input  iss_valid, iss_rd, ex_valid, ex_rd, ex_data, ld_valid, ld_rd, ld_data, q_raddr1, q_raddr2,
    output iss_ready, ex_ready, ld_ready, q_busy1, q_busy2, rf_wen, rf_waddr, rf_wdata
  );
  modport master (
    output iss_valid, iss_rd, ex_valid, ex_rd, ex_data, ld_valid, ld_rd, ld_data, q_raddr1, q_raddr2,
    input  iss_ready, ex_ready, ld_ready, q_busy1, q_busy2, rf_wen, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of write-back entries; extra pointer bit separates full from empty
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t dout,
  output logic      full,
  output logic      empty
);
  localparam int PW = $clog2(DEPTH);
  logic [PW:0] wp, rp;
  wb_entry_t mem [DEPTH];
  assign empty = wp == rp;
  assign full = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign dout = mem[rp[PW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (PW+1)'(1);
      if (pop) rp <= rp + (PW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wp[PW-1:0]] <= din;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges load and execute results onto the register-file write port and tracks pending writes
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_WIDTH = 2
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  logic [CNT_WIDTH-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc, dec;
  wb_entry_t head, sel;
  logic full, empty, ex_xfer, push, pop, sel_v, iss_ok;
  assign bus.ex_ready = !full;
  assign bus.ld_ready = 1'b1;
  assign ex_xfer = bus.ex_valid && !full;
  // loads always win; execute results queue behind them or behind older buffered results
  assign pop = !bus.ld_valid && !empty;
  assign push = ex_xfer && (bus.ld_valid || !empty);
  assign sel_v = bus.ld_valid || !empty || ex_xfer;
  assign sel = bus.ld_valid ? wb_entry_t'{bus.ld_rd, bus.ld_data}
             : !empty       ? head
             :                wb_entry_t'{bus.ex_rd, bus.ex_data};
  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wb_entry_t'{bus.ex_rd, bus.ex_data}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.rf_wen <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else begin
      bus.rf_wen <= sel_v && sel.rd != '0;
      if (sel_v) begin
        bus.rf_waddr <= sel.rd;
        bus.rf_wdata <= sel.data;
      end
    end
  assign bus.iss_ready = cnt[bus.iss_rd] != '1;
  assign bus.q_busy1 = cnt[bus.q_raddr1] != '0;
  assign bus.q_busy2 = cnt[bus.q_raddr2] != '0;
  assign iss_ok = bus.iss_valid && bus.iss_ready && bus.iss_rd != '0;
  assign inc = iss_ok ? NUM_REGS'(1) << bus.iss_rd : '0;
  assign dec = bus.rf_wen ? NUM_REGS'(1) << bus.rf_waddr : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        if (inc[r] && !dec[r]) cnt[r] <= cnt[r] + CNT_WIDTH'(1);
        else if (dec[r] && !inc[r] && cnt[r] != '0) cnt[r] <= cnt[r] - CNT_WIDTH'(1);
    end
  // a writeback with nothing outstanding means decode and the producers disagree
  always_ff @(posedge clk)
    if (rst && bus.rf_wen) assert (cnt[bus.rf_waddr] != '0);
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table, corner sequences and randomized traffic against a queue model
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  localparam int DEPTH = 2;
  localparam int CMAX = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  wb_arbiter_if bus();
  wb_arbiter #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  wb_entry_t mq[$];
  int pend[NUM_REGS];
  int owed[NUM_REGS];
  logic m_wen;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_data;
  typedef struct {
    bit ld_v; logic [4:0] ld_rd; logic [31:0] ld_d;
    bit ex_v; logic [4:0] ex_rd; logic [31:0] ex_d;
    bit iss_v; logic [4:0] iss_rd;
    bit exp_exr; bit exp_wen; logic [4:0] exp_addr; logic [31:0] exp_data;
  } vec_t;
  vec_t vt[14];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.iss_valid = 0; bus.iss_rd = 0;
    bus.ex_valid = 0; bus.ex_rd = 0; bus.ex_data = 0;
    bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0;
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < NUM_REGS; i++) begin
      pend[i] = 0;
      owed[i] = 0;
    end
    m_wen = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic tick();
    bit xfer, have, inc;
    wb_entry_t o, e;
    #1;
    chk("ld_ready", bus.ld_ready, 1);
    chk("ex_ready", bus.ex_ready, mq.size() < DEPTH);
    chk("iss_ready", bus.iss_ready, pend[bus.iss_rd] != CMAX);
    chk("q_busy1", bus.q_busy1, pend[bus.q_raddr1] != 0);
    chk("q_busy2", bus.q_busy2, pend[bus.q_raddr2] != 0);
    e.rd = bus.ex_rd; e.data = bus.ex_data;
    xfer = bus.ex_valid && mq.size() < DEPTH;
    have = 1;
    if (bus.ld_valid) begin
      o.rd = bus.ld_rd; o.data = bus.ld_data;
      if (xfer) mq.push_back(e);
    end else if (mq.size() > 0) begin
      o = mq.pop_front();
      if (xfer) mq.push_back(e);
    end else if (xfer) o = e;
    else have = 0;
    inc = bus.iss_valid && bus.iss_rd != 0 && pend[bus.iss_rd] != CMAX;
    if (inc) begin
      pend[bus.iss_rd]++;
      owed[bus.iss_rd]++;
    end
    if (m_wen) pend[m_addr]--;
    if (m_wen && pend[m_addr] < 0) pend[m_addr] = 0;
    m_wen = have && o.rd != 0;
    if (have) begin
      m_addr = o.rd;
      m_data = o.data;
    end
    @(posedge clk);
    #1;
    chk("rf_wen", bus.rf_wen, m_wen);
    if (m_wen) begin
      chk("rf_waddr", bus.rf_waddr, m_addr);
      chk("rf_wdata", bus.rf_wdata, m_data);
    end
  endtask

  initial begin
    int r;
    bit ok;
    idle();
    bus.q_raddr1 = 0; bus.q_raddr2 = 0;
    model_reset();
    vt[0]  = '{0, 0, 0,      1, 5, 32'h1234, 0, 0, 1, 1, 5, 32'h1234};
    vt[1]  = '{0, 0, 0,      0, 0, 0,        0, 0, 1, 0, 0, 0};
    vt[2]  = '{1, 3, 32'hAA, 1, 4, 32'hBB,   0, 0, 1, 1, 3, 32'hAA};
    vt[3]  = '{0, 0, 0,      0, 0, 0,        0, 0, 1, 1, 4, 32'hBB};
    vt[4]  = '{0, 0, 0,      0, 0, 0,        0, 0, 1, 0, 0, 0};
    vt[5]  = '{1, 8, 32'hA0, 1, 12, 32'hE0,  0, 0, 1, 1, 8, 32'hA0};
    vt[6]  = '{1, 9, 32'hA1, 1, 13, 32'hE1,  0, 0, 1, 1, 9, 32'hA1};
    vt[7]  = '{1, 10, 32'hA2, 1, 14, 32'hE2, 0, 0, 0, 1, 10, 32'hA2};
    vt[8]  = '{1, 11, 32'hA3, 1, 14, 32'hE2, 0, 0, 0, 1, 11, 32'hA3};
    vt[9]  = '{0, 0, 0,      1, 14, 32'hE2,  0, 0, 0, 1, 12, 32'hE0};
    vt[10] = '{0, 0, 0,      1, 14, 32'hE2,  0, 0, 1, 1, 13, 32'hE1};
    vt[11] = '{0, 0, 0,      0, 0, 0,        0, 0, 1, 1, 14, 32'hE2};
    vt[12] = '{0, 0, 0,      0, 0, 0,        0, 0, 1, 0, 0, 0};
    vt[13] = '{0, 0, 0,      1, 0, 32'hFFFF, 1, 0, 1, 0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wen", bus.rf_wen, 0);
    chk("reset_waddr", bus.rf_waddr, 0);
    chk("reset_wdata", bus.rf_wdata, 0);
    chk("reset_ex_ready", bus.ex_ready, 1);
    @(negedge clk) rst = 1;
    foreach (vt[i]) if (vt[i].ex_rd != 0 || vt[i].ld_rd != 0) begin
      bus.iss_valid = 1;
      bus.iss_rd = vt[i].ld_v ? vt[i].ld_rd : vt[i].ex_rd;
      if (vt[i].ld_v) tick();
      if (vt[i].ex_v && vt[i].ex_rd != 0 && (i < 8 || i > 10)) begin
        bus.iss_rd = vt[i].ex_rd;
        tick();
      end
    end
    idle();
    foreach (vt[i]) begin
      bus.ld_valid = vt[i].ld_v; bus.ld_rd = vt[i].ld_rd; bus.ld_data = vt[i].ld_d;
      bus.ex_valid = vt[i].ex_v; bus.ex_rd = vt[i].ex_rd; bus.ex_data = vt[i].ex_d;
      bus.iss_valid = vt[i].iss_v; bus.iss_rd = vt[i].iss_rd;
      #1;
      chk($sformatf("vec%0d_ex_ready", i), bus.ex_ready, vt[i].exp_exr);
      tick();
      chk($sformatf("vec%0d_wen", i), bus.rf_wen, vt[i].exp_wen);
      if (vt[i].exp_wen) begin
        chk($sformatf("vec%0d_waddr", i), bus.rf_waddr, vt[i].exp_addr);
        chk($sformatf("vec%0d_wdata", i), bus.rf_wdata, vt[i].exp_data);
      end
    end
    idle();
    bus.q_raddr1 = 0;
    #1;
    chk("r0_busy", bus.q_busy1, 0);
    bus.iss_valid = 1; bus.iss_rd = 7;
    repeat (3) tick();
    bus.iss_valid = 0;
    bus.q_raddr1 = 7;
    #1;
    chk("r7_saturated", bus.iss_ready, 0);
    chk("r7_busy", bus.q_busy1, 1);
    for (int k = 0; k < 3; k++) begin
      bus.ex_valid = 1; bus.ex_rd = 7; bus.ex_data = 32'h700 + k;
      tick();
      chk("r7_wb", bus.rf_wen, 1);
    end
    idle();
    chk("r7_busy_at_last_wb", bus.q_busy1, 1);
    tick();
    chk("r7_busy_cleared", bus.q_busy1, 0);
    chk("r7_iss_ready", bus.iss_ready, 1);
    for (int k = 20; k < 24; k++) begin
      bus.iss_valid = 1; bus.iss_rd = k[4:0];
      tick();
    end
    idle();
    bus.ld_valid = 1; bus.ld_rd = 20; bus.ld_data = 32'h20;
    bus.ex_valid = 1; bus.ex_rd = 21; bus.ex_data = 32'h21;
    tick();
    bus.ld_rd = 22; bus.ld_data = 32'h22;
    bus.ex_rd = 23; bus.ex_data = 32'h23;
    tick();
    idle();
    bus.q_raddr1 = 21; bus.q_raddr2 = 23;
    #1;
    chk("pre_reset_full", bus.ex_ready, 0);
    rst = 0;
    #1;
    chk("midrst_wen", bus.rf_wen, 0);
    chk("midrst_ex_ready", bus.ex_ready, 1);
    chk("midrst_busy1", bus.q_busy1, 0);
    chk("midrst_busy2", bus.q_busy2, 0);
    model_reset();
    @(negedge clk) rst = 1;
    tick();
    tick();
    chk("no_write_after_reset", bus.rf_wen, 0);
    for (int c = 0; c < 400; c++) begin
      idle();
      bus.q_raddr1 = 5'($urandom_range(0, 7));
      bus.q_raddr2 = 5'($urandom_range(0, 7));
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_rd = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 3) begin
        r = $urandom_range(0, 7);
        if (r == 0 || owed[r] > 0) begin
          bus.ld_valid = 1; bus.ld_rd = 5'(r); bus.ld_data = $urandom;
          if (r != 0) owed[r]--;
        end
      end
      if ($urandom_range(0, 9) < 5) begin
        r = $urandom_range(0, 7);
        ok = r == 0 || owed[r] > 0;
        if (ok) begin
          bus.ex_valid = 1; bus.ex_rd = 5'(r); bus.ex_data = $urandom;
          if (r != 0 && mq.size() < DEPTH) owed[r]--;
        end
      end
      tick();
    end
    idle();
    repeat (6) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
